// File: rtl/zmod_adc_pkg.sv
// Shared definitions for the Zmod Scope ADC (AD9648) driver.
// Contents: configuration FSM state type, SPI frame geometry, ADC sample width,
// and the fixed power-up register table with a helper that builds SPI frames.
package zmod_adc_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } cfg_state_t;

  localparam int unsigned SPI_FRAME_W = 24;
  localparam int unsigned ADC_W       = 14;
  localparam int unsigned CFG_LEN     = 4;
  localparam int unsigned CFG_IDX_W   = 2;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

  // Soft reset, normal power, two's-complement output, then transfer.
  localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
    '{addr: 13'h000, data: 8'h3C},
    '{addr: 13'h008, data: 8'h00},
    '{addr: 13'h014, data: 8'h01},
    '{addr: 13'h0FF, data: 8'h01}
  };

  // Write command, single-byte transfer: {R/W=0, W1:W0=00, addr, data}.
  function automatic logic [SPI_FRAME_W-1:0] cfg_frame(input logic [CFG_IDX_W-1:0] idx);
    return {3'b000, CFG_TABLE[idx]};
  endfunction

endpackage

// File: rtl/zmod_adc_spi_master.sv
// Write-only 3-wire SPI master (mode 0, MSB first) for one 24-bit frame.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : begin a frame (accepted only while not busy)
//   frame         : 24-bit word to send
//   busy          : frame in progress
//   done          : one-cycle pulse when CS has returned high
//   sck, cs, sdio : SPI pins; sck idles low, cs is active low
module zmod_adc_spi_master
  import zmod_adc_pkg::*;
#(
  parameter int unsigned SPI_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SPI_FRAME_W-1:0] frame,
  output logic                   busy,
  output logic                   done,
  output logic                   sck,
  output logic                   cs,
  output logic                   sdio
);

  // 48 SCK half-periods carry the 24 bits; one more half-period ends the frame.
  localparam logic [5:0] LAST_HALF = 6'(2 * SPI_FRAME_W);

  logic                   active_reg;
  logic [7:0]             div_reg;
  logic [5:0]             half_reg;
  logic [SPI_FRAME_W-1:0] shift_reg;
  logic                   sck_reg;
  logic                   cs_reg;
  logic                   sdio_reg;
  logic                   done_reg;
  logic                   half_tick;

  assign half_tick = (div_reg == 8'(SPI_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      half_reg   <= '0;
      shift_reg  <= '0;
      sck_reg    <= 1'b0;
      cs_reg     <= 1'b1;
      sdio_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (!active_reg) begin
        if (start) begin
          // First bit goes out with CS; the shifter holds the remaining bits.
          active_reg <= 1'b1;
          cs_reg     <= 1'b0;
          sck_reg    <= 1'b0;
          sdio_reg   <= frame[SPI_FRAME_W-1];
          shift_reg  <= frame << 1;
          div_reg    <= '0;
          half_reg   <= '0;
        end
      end else if (half_tick) begin
        div_reg  <= '0;
        half_reg <= half_reg + 6'd1;
        if (half_reg == LAST_HALF) begin
          active_reg <= 1'b0;
          cs_reg     <= 1'b1;
          sdio_reg   <= 1'b0;
          done_reg   <= 1'b1;
        end else begin
          sck_reg <= ~sck_reg;
          // Data only moves on the falling edge so it is stable at the rise.
          if (sck_reg) begin
            sdio_reg  <= shift_reg[SPI_FRAME_W-1];
            shift_reg <= shift_reg << 1;
          end
        end
      end else begin
        div_reg <= div_reg + 8'd1;
      end
    end
  end

  assign busy = active_reg;
  assign done = done_reg;
  assign sck  = sck_reg;
  assign cs   = cs_reg;
  assign sdio = sdio_reg;

endmodule

// File: rtl/zmod_adc_driver.sv
// Zmod Scope ADC driver: configures the AD9648 over SPI after reset, then
// captures the DDR data bus (ch A rising, ch B falling) into two aligned
// signed 14-bit streams with a valid strobe.
// Ports:
//   clk, rst          : sample clock, synchronous active-high reset
//   is14_adc_data     : DDR data from the ADC
//   i_run             : capture enable
//   os14_data_a/b     : signed samples, zero when not valid
//   o_data_valid      : samples valid this cycle
//   o_config_done     : register table fully written
//   or_sck/or_cs/o_sdio : SPI pins
//   o_sync, o_relay_coupling, o_relay_gain : fixed board controls
module zmod_adc_driver
  import zmod_adc_pkg::*;
#(
  parameter int unsigned SPI_DIV      = 4,
  parameter int unsigned PWRUP_CYCLES = 1000,
  parameter int unsigned CS_GAP       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADC_W-1:0]        is14_adc_data,
  input  logic                    i_run,
  output logic signed [ADC_W-1:0] os14_data_a,
  output logic signed [ADC_W-1:0] os14_data_b,
  output logic                    o_data_valid,
  output logic                    o_config_done,
  output logic                    or_sck,
  output logic                    or_cs,
  output logic                    o_sdio,
  output logic                    o_sync,
  output logic                    o_relay_coupling,
  output logic                    o_relay_gain
);

  localparam logic [CFG_IDX_W-1:0] LAST_IDX = CFG_IDX_W'(CFG_LEN - 1);

  cfg_state_t           state_reg, state_next;
  logic [CFG_IDX_W-1:0] idx_reg, idx_next;
  logic [31:0]          cnt_reg, cnt_next;
  logic                 spi_start;
  logic                 spi_busy;
  logic                 spi_done;
  logic                 config_done;

  zmod_adc_spi_master #(
    .SPI_DIV(SPI_DIV)
  ) u_spi (
    .clk  (clk),
    .rst  (rst),
    .start(spi_start),
    .frame(cfg_frame(idx_reg)),
    .busy (spi_busy),
    .done (spi_done),
    .sck  (or_sck),
    .cs   (or_cs),
    .sdio (o_sdio)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_WAIT;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    spi_start  = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        if (cnt_reg == 32'(PWRUP_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = ST_LOAD;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_LOAD: begin
        if (!spi_busy) begin
          spi_start  = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          cnt_next   = '0;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        // CS is already high here; this only stretches the inter-frame gap.
        if (cnt_reg == 32'(CS_GAP - 1)) begin
          cnt_next = '0;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_LOAD;
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

  assign config_done = (state_reg == ST_DONE);

  // Per-bit IDDR (same-edge pipelined) model: edge-capture flops, an
  // alignment stage that brings the falling sample onto the rising edge
  // beside its rising partner, and the IDDR Q flops.
  logic [ADC_W-1:0] iddr_q1;
  logic [ADC_W-1:0] iddr_q2;

  for (genvar gi = 0; gi < ADC_W; gi++) begin : g_iddr
    logic rise_cap_reg;
    logic fall_cap_reg;
    logic align_a_reg;
    logic align_b_reg;
    logic q1_reg;
    logic q2_reg;

    always_ff @(posedge clk) begin
      rise_cap_reg <= is14_adc_data[gi];
      align_a_reg  <= rise_cap_reg;
      align_b_reg  <= fall_cap_reg;
      q1_reg       <= align_a_reg;
      q2_reg       <= align_b_reg;
    end

    always_ff @(negedge clk) begin
      fall_cap_reg <= is14_adc_data[gi];
    end

    assign iddr_q1[gi] = q1_reg;
    assign iddr_q2[gi] = q2_reg;
  end

  logic             valid_reg;
  logic [ADC_W-1:0] data_a_reg;
  logic [ADC_W-1:0] data_b_reg;

  // Gating uses the live enable so the outputs drop one cycle after i_run.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg  <= 1'b0;
      data_a_reg <= '0;
      data_b_reg <= '0;
    end else begin
      valid_reg <= config_done & i_run;
      if (config_done & i_run) begin
        data_a_reg <= iddr_q1;
        data_b_reg <= iddr_q2;
      end else begin
        data_a_reg <= '0;
        data_b_reg <= '0;
      end
    end
  end

  assign os14_data_a      = data_a_reg;
  assign os14_data_b      = data_b_reg;
  assign o_data_valid     = valid_reg;
  assign o_config_done    = config_done;
  assign o_sync           = 1'b0;
  assign o_relay_coupling = 1'b1;
  assign o_relay_gain     = 1'b0;

endmodule
